game_screen_sequencer: RTL

GAME_SCREEN_SEQUENCER -- requirements
Module: game_screen_sequencer

---
 rtl/game_screen_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/game_screen_sequencer.sv
// Screen sequencer for a timed game round: LOGO -> GET_READY -> PLAY -> TIMES_UP -> LEADERBOARD.
// A shared one-second prescaler drives the per-screen countdown; all outputs are registered.
module game_screen_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int READY_SECS    = 3,
  parameter int PLAY_SECS     = 60,
  parameter int TIMESUP_SECS  = 2,
  parameter int LEADER_SECS   = 10
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       abort,
  input  logic       two_player_mode,
  output logic [2:0] screen,
  output logic       logo,
  output logic       get_ready,
  output logic       play_active,
  output logic       times_up,
  output logic       leaderboard,
  output logic [7:0] seconds_left,
  output logic       sec_tick,
  output logic       end_of_game,
  output logic       dual_latched
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_LOGO      = 3'd0,
    S_GET_READY = 3'd1,
    S_PLAY      = 3'd2,
    S_TIMES_UP  = 3'd3,
    S_LEADER    = 3'd4
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic            r_start_d;
  logic [7:0]      r_secs;
  logic            r_dual;
  logic            r_logo;
  logic            r_get_ready;
  logic            r_play_active;
  logic            r_times_up;
  logic            r_leaderboard;
  logic            r_sec_tick;
  logic            r_end_of_game;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_presc_nxt;
  logic [7:0]      w_secs_nxt;
  logic            w_dual_nxt;
  logic            w_start_edge;
  logic            w_tick;
  logic            w_expire;

  always_comb begin
    w_start_edge = start & ~r_start_d;
    w_tick       = (r_state != S_LOGO) && (r_presc == PRESC_LAST);
    w_expire     = w_tick && (r_secs == 8'd1);
    w_state_nxt  = r_state;
    w_presc_nxt  = w_tick ? '0 : r_presc + 1'b1;
    w_secs_nxt   = w_tick ? r_secs - 8'd1 : r_secs;
    w_dual_nxt   = r_dual;

    case (r_state)
      S_LOGO: begin
        w_presc_nxt = '0;
        w_secs_nxt  = 8'd0;
        w_dual_nxt  = 1'b0;
        if (w_start_edge) begin
          w_state_nxt = S_GET_READY;
          w_secs_nxt  = 8'(READY_SECS);
          w_dual_nxt  = two_player_mode;
        end
      end
      S_GET_READY: begin
        if (w_expire) begin
          w_state_nxt = S_PLAY;
          w_secs_nxt  = 8'(PLAY_SECS);
        end
      end
      S_PLAY: begin
        // Abort and expiry collapse into the same single transition.
        if (abort || w_expire) begin
          w_state_nxt = S_TIMES_UP;
          w_secs_nxt  = 8'(TIMESUP_SECS);
          w_presc_nxt = '0;
        end
      end
      S_TIMES_UP: begin
        if (w_expire) begin
          w_state_nxt = S_LEADER;
          w_secs_nxt  = 8'(LEADER_SECS);
        end
      end
      S_LEADER: begin
        if (w_start_edge) begin
          w_state_nxt = S_GET_READY;
          w_secs_nxt  = 8'(READY_SECS);
          w_presc_nxt = '0;
          w_dual_nxt  = two_player_mode;
        end else if (w_expire) begin
          w_state_nxt = S_LOGO;
          w_secs_nxt  = 8'd0;
          w_presc_nxt = '0;
          w_dual_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_LOGO;
        w_secs_nxt  = 8'd0;
        w_presc_nxt = '0;
        w_dual_nxt  = 1'b0;
      end
    endcase
  end

  // Outputs are loaded from the next-state values so they line up with the state register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state       <= S_LOGO;
      r_presc       <= '0;
      r_start_d     <= 1'b1;
      r_secs        <= 8'd0;
      r_dual        <= 1'b0;
      r_logo        <= 1'b1;
      r_get_ready   <= 1'b0;
      r_play_active <= 1'b0;
      r_times_up    <= 1'b0;
      r_leaderboard <= 1'b0;
      r_sec_tick    <= 1'b0;
      r_end_of_game <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_presc       <= w_presc_nxt;
      r_start_d     <= start;
      r_secs        <= w_secs_nxt;
      r_dual        <= w_dual_nxt;
      r_logo        <= (w_state_nxt == S_LOGO);
      r_get_ready   <= (w_state_nxt == S_GET_READY);
      r_play_active <= (w_state_nxt == S_PLAY);
      r_times_up    <= (w_state_nxt == S_TIMES_UP);
      r_leaderboard <= (w_state_nxt == S_LEADER);
      r_sec_tick    <= (w_state_nxt != S_LOGO) && (w_presc_nxt == PRESC_LAST);
      r_end_of_game <= (w_state_nxt == S_TIMES_UP) && (r_state != S_TIMES_UP);
    end
  end

  assign screen       = r_state;
  assign logo         = r_logo;
  assign get_ready    = r_get_ready;
  assign play_active  = r_play_active;
  assign times_up     = r_times_up;
  assign leaderboard  = r_leaderboard;
  assign seconds_left = r_secs;
  assign sec_tick     = r_sec_tick;
  assign end_of_game  = r_end_of_game;
  assign dual_latched = r_dual;

endmodule
